crc5_check: RTL and testbench

- Receive-side USB CRC5 checker; the counterpart of the token CRC5 generator on the transmit path.
- Accepts the serial token field after NRZI decode and bit-unstuffing: DATA_BITS data bits (LSB first) followed by 5 CRC bits (complemented CRC, MSB first, as the generator emits them).
- Runs all bits through the x^5+x^2+1 LFSR and compares against the USB residual 5'b01100.
- Captures the data field in parallel and reports ok/err to the packet decoder through a done/rec handshake.

---
 rtl/crc5_check.sv | 143 ++++++++++++++
 tb/tb_crc5_check.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/crc5_check.sv
// Receive-side USB CRC5 checker: deserialises a token field, checks the x^5+x^2+1 residual.
// Define CRC5_ERR_CNT_EN to build the saturating error counter behind err_cnt.
module crc5_check #(
    parameter int unsigned DATA_BITS = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 crc5_start,
    input  logic                 s_in,
    input  logic                 s_valid,
    input  logic                 abort,
    input  logic                 crc5_rec,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 crc5_busy,
    output logic                 crc5_done,
    output logic                 crc5_ok,
    output logic                 crc5_err,
    output logic [7:0]           err_cnt
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StData = 2'd1;
    localparam logic [1:0] StCrc  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [4:0] Residual = 5'b01100;

    logic [1:0]           r_state, w_state_d;
    logic [4:0]           r_lfsr, w_lfsr_d;
    logic [4:0]           r_cnt, w_cnt_d;
    logic [DATA_BITS-1:0] r_data, w_data_d;
    logic                 r_done, w_done_d;
    logic                 r_ok, w_ok_d;
    logic                 r_err, w_err_d;

    logic                 w_fb;
    logic [4:0]           w_lfsr_nxt;

    assign w_fb       = r_lfsr[4] ^ s_in;
    assign w_lfsr_nxt = {r_lfsr[3], r_lfsr[2], r_lfsr[1] ^ w_fb, r_lfsr[0], w_fb};

    always_comb begin
        w_state_d = r_state;
        w_lfsr_d  = r_lfsr;
        w_cnt_d   = r_cnt;
        w_data_d  = r_data;
        w_done_d  = r_done;
        w_ok_d    = r_ok;
        w_err_d   = r_err;
        case (r_state)
            StIdle: begin
                if (crc5_start) begin
                    w_state_d = StData;
                    w_lfsr_d  = 5'b11111;
                    w_cnt_d   = 5'd0;
                end
            end
            StData, StCrc: begin
                // Abort wins over a bit arriving in the same cycle.
                if (abort) begin
                    w_state_d = StDone;
                    w_cnt_d   = 5'd0;
                    w_done_d  = 1'b1;
                    w_ok_d    = 1'b0;
                    w_err_d   = 1'b1;
                end else if (s_valid) begin
                    w_lfsr_d = w_lfsr_nxt;
                    w_cnt_d  = r_cnt + 5'd1;
                    if (r_state == StData) begin
                        for (int i = 0; i < int'(DATA_BITS); i++) begin
                            if (r_cnt == 5'(i)) w_data_d[i] = s_in;
                        end
                        if (r_cnt == 5'(DATA_BITS - 1)) begin
                            w_state_d = StCrc;
                            w_cnt_d   = 5'd0;
                        end
                    end else if (r_cnt == 5'd4) begin
                        w_state_d = StDone;
                        w_cnt_d   = 5'd0;
                        w_done_d  = 1'b1;
                        w_ok_d    = (w_lfsr_nxt == Residual);
                        w_err_d   = (w_lfsr_nxt != Residual);
                    end
                end
            end
            default: begin
                if (crc5_rec) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b0;
                    w_ok_d    = 1'b0;
                    w_err_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_lfsr  <= 5'b11111;
            r_cnt   <= 5'd0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_lfsr  <= w_lfsr_d;
            r_cnt   <= w_cnt_d;
            r_data  <= w_data_d;
            r_done  <= w_done_d;
            r_ok    <= w_ok_d;
            r_err   <= w_err_d;
        end
    end

`ifdef CRC5_ERR_CNT_EN
    logic [7:0] r_err_cnt;
    logic       w_err_entry;

    assign w_err_entry = (r_state == StData || r_state == StCrc) &&
                         (w_state_d == StDone) && w_err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= 8'h00;
        end else if (w_err_entry && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'h00;
`endif

    assign crc5_busy = (r_state == StData) || (r_state == StCrc);
    assign crc5_done = r_done;
    assign crc5_ok   = r_ok;
    assign crc5_err  = r_err;
    assign data_out  = r_data;

endmodule

// File: tb/tb_crc5_check.sv
// Randomised bench for crc5_check against a polynomial-division reference model.
module tb_crc5_check;
    localparam int unsigned DB = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          crc5_start = 1'b0, s_in = 1'b0, s_valid = 1'b0, abort = 1'b0, crc5_rec = 1'b0;
    logic [DB-1:0] data_out;
    logic          crc5_busy, crc5_done, crc5_ok, crc5_err;
    logic [7:0]    err_cnt;

    int total = 0;
    int bad   = 0;

    crc5_check #(.DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .crc5_start (crc5_start),
        .s_in       (s_in),
        .s_valid    (s_valid),
        .abort      (abort),
        .crc5_rec   (crc5_rec),
        .data_out   (data_out),
        .crc5_busy  (crc5_busy),
        .crc5_done  (crc5_done),
        .crc5_ok    (crc5_ok),
        .crc5_err   (crc5_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // CRC the transmitter appends: complement of (preset-adjusted message * x^5) mod x^5+x^2+1.
    function automatic logic [4:0] crc_of(input logic [DB-1:0] d);
        logic [63:0] v;
        v = 64'h1F << DB;
        for (int i = 0; i < int'(DB); i++)
            if (d[i]) v ^= 64'd1 << (DB - 1 - i + 5);
        for (int b = DB + 4; b >= 5; b--)
            if (v[b]) v ^= 64'h25 << (b - 5);
        return ~v[4:0];
    endfunction

    // Reference model: 0 idle, 1 receiving, 2 result held.
    int            m_phase = 0;
    int            m_n = 0;
    logic [DB-1:0] m_data = '0;
    logic [4:0]    m_crc = '0;
    logic          m_ok = 1'b0, m_err = 1'b0, m_dchk = 1'b1;
    logic [7:0]    m_errcnt = 8'h00;

    task automatic m_bump();
`ifdef CRC5_ERR_CNT_EN
        if (m_errcnt != 8'hFF) m_errcnt++;
`endif
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_n = 0; m_data = '0; m_ok = 0; m_err = 0; m_dchk = 1; m_errcnt = 0;
        end else begin
            case (m_phase)
                0: if (crc5_start) begin m_phase = 1; m_n = 0; m_dchk = 0; end
                1: if (abort) begin
                    m_phase = 2; m_ok = 0; m_err = 1; m_bump();
                end else if (s_valid) begin
                    if (m_n < int'(DB)) m_data[m_n] = s_in;
                    else m_crc = {m_crc[3:0], s_in};
                    m_n++;
                    if (m_n == int'(DB) + 5) begin
                        m_ok = (m_crc == crc_of(m_data));
                        m_err = !m_ok;
                        if (m_err) m_bump();
                        m_phase = 2; m_dchk = 1;
                    end
                end
                default: if (crc5_rec) begin m_phase = 0; m_ok = 0; m_err = 0; end
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        check("busy", crc5_busy, m_phase == 1);
        check("done", crc5_done, m_phase == 2);
        if (m_phase == 2) begin
            check("ok", crc5_ok, m_ok);
            check("err", crc5_err, m_err);
        end
        if (m_dchk) check("data_out", data_out, m_data);
        check("err_cnt", err_cnt, m_errcnt);
    end

    task automatic cyc(input logic st, input logic sv, input logic si, input logic ab,
                       input logic rc);
        @(negedge clk);
        crc5_start = st; s_valid = sv; s_in = si; abort = ab; crc5_rec = rc;
    endtask

    task automatic send_bit(input logic b, input int gap);
        for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic send_field(input logic [DB-1:0] d, input logic [4:0] c, input int gap);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < int'(DB); i++) send_bit(d[i], gap);
        for (int j = 4; j >= 0; j--) send_bit(c[j], gap);
    endtask

    task automatic ack();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_cnt1;

    initial begin
`ifdef CRC5_ERR_CNT_EN
        exp_cnt1 = 8'h01;
`else
        exp_cnt1 = 8'h00;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", crc5_busy, 1'b0);
        check("rst_done", crc5_done, 1'b0);
        check("rst_data", data_out, 0);
        check("rst_errcnt", err_cnt, 8'h00);
        rst = 1'b0;

        check("model_crc_zero", crc_of('0), 5'b01000);

        // Good CRC on all-zero data.
        send_field('0, 5'b01000, 0);
        post_edge();
        check("good_done", crc5_done, 1'b1);
        check("good_ok", crc5_ok, 1'b1);
        check("good_err", crc5_err, 1'b0);
        check("good_data", data_out, 0);
        ack();
        check("good_idle", crc5_done, 1'b0);

        // Last CRC bit flipped.
        send_field('0, 5'b01001, 0);
        post_edge();
        check("bad_ok", crc5_ok, 1'b0);
        check("bad_err", crc5_err, 1'b1);
        check("bad_errcnt", err_cnt, exp_cnt1);
        ack();

        // Three idle cycles around every bit.
        send_field('0, 5'b01000, 3);
        post_edge();
        check("gap_ok", crc5_ok, 1'b1);
        ack();

        // Abort alongside the seventh bit.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) send_bit(1'($urandom), 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        post_edge();
        check("abort_done", crc5_done, 1'b1);
        check("abort_err", crc5_err, 1'b1);
        check("abort_ok", crc5_ok, 1'b0);
        ack();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        post_edge();
        check("idle_abort_busy", crc5_busy, 1'b0);
        check("idle_abort_done", crc5_done, 1'b0);

        // Result held unacknowledged while start is pulsed.
        send_field(11'h5A3, crc_of(11'h5A3), 0);
        for (int k = 0; k < 20; k++) begin
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            post_edge();
            check("hold_done", crc5_done, 1'b1);
            check("hold_ok", crc5_ok, 1'b1);
            check("hold_data", data_out, 11'h5A3);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rec_start_busy", crc5_busy, 1'b0);
        check("rec_start_done", crc5_done, 1'b0);
        send_field(11'h2B6, crc_of(11'h2B6), 0);
        post_edge();
        check("fresh_ok", crc5_ok, 1'b1);
        ack();

        // Reset in the middle of the data field.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b1, 0);
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_busy", crc5_busy, 1'b0);
        check("midrst_data", data_out, 0);
        check("midrst_done", crc5_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        send_field('0, 5'b01000, 0);
        post_edge();
        check("postrst_ok", crc5_ok, 1'b1);
        ack();

        // Random fields: bad CRCs, gaps, aborts, slow acknowledges.
        for (int f = 0; f < 60; f++) begin
            logic [DB-1:0] d;
            logic [4:0]    c;
            int            ab_at;
            d = DB'($urandom);
            c = crc_of(d) ^ (($urandom_range(0, 1) == 1) ? 5'($urandom_range(1, 31)) : 5'd0);
            ab_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, DB + 4)) : -1;
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < int'(DB) + 5; i++) begin
                logic b;
                b = (i < int'(DB)) ? d[i] : c[int'(DB) + 4 - i];
                if (i == ab_at) begin
                    cyc(1'b0, 1'($urandom), b, 1'b1, 1'b0);
                    break;
                end
                send_bit(b, int'($urandom_range(0, 2)));
            end
            repeat ($urandom_range(0, 3)) cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
            ack();
        end

        // Saturate the error counter with aborted fields.
        for (int f = 0; f < 300; f++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CRC5_ERR_CNT_EN
        check("errcnt_sat", err_cnt, 8'hFF);
`else
        check("errcnt_tied", err_cnt, 8'h00);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
